// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory-stage requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view and the master modport is the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  IReq;
  logic [DATA_WIDTH-1:0] IAddr;
  logic [DATA_WIDTH-1:0] IRData;
  logic                  IValid;
  logic                  StallI;

  logic                  DReq;
  logic                  DWe;
  logic [DATA_WIDTH-1:0] DAddr;
  logic [DATA_WIDTH-1:0] DWData;
  logic [2:0]            DCtrl;
  logic [DATA_WIDTH-1:0] DRData;
  logic                  DValid;
  logic                  StallD;

  logic                  MemReq;
  logic                  MemWe;
  logic [DATA_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemWData;
  logic [2:0]            MemCtrl;
  logic [DATA_WIDTH-1:0] MemRData;
  logic                  MemReady;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, DCtrl, MemRData, MemReady,
    output IRData, IValid, StallI, DRData, DValid, StallD,
           MemReq, MemWe, MemAddr, MemWData, MemCtrl
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, DCtrl, MemRData, MemReady,
    input  IRData, IValid, StallI, DRData, DValid, StallD,
           MemReq, MemWe, MemAddr, MemWData, MemCtrl
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between I-side fetch and D-side load/store.
// Grants are registered, D-side has priority, and I-side gets the slot after MAX_WAIT refused cycles.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [2:0]        CTRL_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            ctrl_q, ctrl_d;

  logic done, arb, i_ok, d_ok, grant_i, grant_d;

  // The side finishing this cycle still holds its request, so it is masked out of the new arbitration.
  always_comb begin
    done    = (state_q != IDLE) && bus.MemReady;
    arb     = (state_q == IDLE) || done;
    i_ok    = bus.IReq && (state_q != SERVE_I);
    d_ok    = bus.DReq && (state_q != SERVE_D);
    grant_d = arb && d_ok && !(i_ok && (wait_cnt == WAIT_MAX));
    grant_i = arb && !grant_d && i_ok;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    if (arb) begin
      state_d = IDLE;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      ctrl_d  = '0;
      if (grant_d) begin
        state_d = SERVE_D;
        we_d    = bus.DWe;
        addr_d  = bus.DAddr;
        wdata_d = bus.DWData;
        ctrl_d  = bus.DCtrl;
      end else if (grant_i) begin
        state_d = SERVE_I;
        addr_d  = bus.IAddr;
        ctrl_d  = CTRL_WORD;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt;
    if (grant_i || !bus.IReq) begin
      wait_cnt_d = '0;
    end else if ((state_q != SERVE_I) && (wait_cnt != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Latched fields are zeroed whenever the FSM returns to IDLE, so the memory side can drive them directly.
  always_comb begin
    bus.MemReq   = (state_q != IDLE);
    bus.MemWe    = we_q;
    bus.MemAddr  = addr_q;
    bus.MemWData = wdata_q;
    bus.MemCtrl  = ctrl_q;
    bus.IValid   = (state_q == SERVE_I) && bus.MemReady;
    bus.DValid   = (state_q == SERVE_D) && bus.MemReady;
    bus.IRData   = bus.MemRData;
    bus.DRData   = bus.MemRData;
    bus.StallI   = bus.IReq && !bus.IValid;
    bus.StallD   = bus.DReq && !bus.DValid;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions are queued as requests are raised
// and compared when the arbiter completes them. Cycle-level checks cover reset, stalls, latching and abort.
module tb_mem_port_arbiter;
  localparam logic [31:0] RD_KEY = 32'hA5C3_0F96;

  typedef struct {
    logic        side_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } txn_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  txn_t sb[$];
  txn_t exp_txn;

  mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model returns a fixed function of the address so expected read data follows from the bench's own address
  assign bus.MemRData = bus.MemAddr ^ RD_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata, input logic [2:0] dctrl,
                               input logic mready);
    bus.IReq     = ireq;
    bus.IAddr    = iaddr;
    bus.DReq     = dreq;
    bus.DWe      = dwe;
    bus.DAddr    = daddr;
    bus.DWData   = dwdata;
    bus.DCtrl    = dctrl;
    bus.MemReady = mready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic side_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ctrl);
    txn_t t;
    t.side_d = side_d;
    t.we     = we;
    t.addr   = addr;
    t.wdata  = wdata;
    t.ctrl   = ctrl;
    sb.push_back(t);
  endtask

  // Completion monitor: every MemReady cycle of an active transaction retires one scoreboard entry
  always @(negedge clk) begin
    if (bus.MemReq && bus.MemReady) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_txn", 32'd1, 32'd0);
      end else begin
        exp_txn = sb.pop_front();
        checkOutput("sb_addr",   bus.MemAddr, exp_txn.addr);
        checkOutput("sb_we",     32'(bus.MemWe), 32'(exp_txn.we));
        checkOutput("sb_wdata",  bus.MemWData, exp_txn.wdata);
        checkOutput("sb_ctrl",   32'(bus.MemCtrl), 32'(exp_txn.ctrl));
        checkOutput("sb_ivalid", 32'(bus.IValid), 32'(!exp_txn.side_d));
        checkOutput("sb_dvalid", 32'(bus.DValid), 32'(exp_txn.side_d));
        if (exp_txn.side_d)
          checkOutput("sb_drdata", bus.DRData, exp_txn.addr ^ RD_KEY);
        else
          checkOutput("sb_irdata", bus.IRData, exp_txn.addr ^ RD_KEY);
      end
    end else if (bus.MemReq) begin
      checkOutput("busy_no_valid", 32'(bus.IValid | bus.DValid), 32'd0);
    end else begin
      checkOutput("idle_mem_we",    32'(bus.MemWe), 32'd0);
      checkOutput("idle_mem_addr",  bus.MemAddr, 32'd0);
      checkOutput("idle_mem_wdata", bus.MemWData, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;

    // Both requests held through a two-cycle reset; nothing may be granted until reset drops
    rst = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b100, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("rst_memreq", 32'(bus.MemReq), 32'd0);
      checkOutput("rst_ivalid", 32'(bus.IValid), 32'd0);
      checkOutput("rst_dvalid", 32'(bus.DValid), 32'd0);
      checkOutput("rst_waitcnt", 32'(dut.wait_cnt), 32'd0);
    end
    pushExpect(1'b1, 1'b0, 32'h2000, 32'h0, 3'b100);
    pushExpect(1'b0, 1'b0, 32'h100, 32'h0, 3'b010);
    rst = 1'b0;
    #1;
    checkOutput("rel_no_grant_yet", 32'(bus.MemReq), 32'd0);
    tick();
    checkOutput("rel_d_first", 32'(bus.DValid), 32'd1);
    checkOutput("rel_d_addr", bus.MemAddr, 32'h2000);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("rel_i_second", 32'(bus.IValid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("rel_idle", 32'(bus.MemReq), 32'd0);

    // Single I-side fetch with an immediately ready memory
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    #1;
    checkOutput("i_stall_c0", 32'(bus.StallI), 32'd1);
    checkOutput("i_memreq_c0", 32'(bus.MemReq), 32'd0);
    pushExpect(1'b0, 1'b0, 32'h100, 32'h0, 3'b010);
    tick();
    checkOutput("i_memreq_c1", 32'(bus.MemReq), 32'd1);
    checkOutput("i_ctrl_c1", 32'(bus.MemCtrl), 32'd2);
    checkOutput("i_valid_c1", 32'(bus.IValid), 32'd1);
    checkOutput("i_stall_c1", 32'(bus.StallI), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("i_idle_c2", 32'(bus.MemReq), 32'd0);
    checkOutput("i_idle_ctrl", 32'(bus.MemCtrl), 32'd0);

    // Simultaneous requests: D first, then I back-to-back
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h2008, 32'h0, 3'b001, 1'b1);
    pushExpect(1'b1, 1'b0, 32'h2008, 32'h0, 3'b001);
    pushExpect(1'b0, 1'b0, 32'h104, 32'h0, 3'b010);
    tick();
    checkOutput("both_d_valid", 32'(bus.DValid), 32'd1);
    checkOutput("both_i_wait", 32'(bus.IValid), 32'd0);
    checkOutput("both_stall_i", 32'(bus.StallI), 32'd1);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("both_i_no_gap", 32'(bus.MemReq), 32'd1);
    checkOutput("both_i_addr", bus.MemAddr, 32'h104);
    checkOutput("both_i_valid", 32'(bus.IValid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("both_idle", 32'(bus.MemReq), 32'd0);

    // Slow D load while I waits: wait count saturates, then I beats a re-requesting D
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 1'b0);
    pushExpect(1'b1, 1'b0, 32'h2000, 32'h0, 3'b010);
    pushExpect(1'b0, 1'b0, 32'h140, 32'h0, 3'b010);
    pushExpect(1'b1, 1'b0, 32'h2004, 32'h0, 3'b010);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("starve_wait_%0d", k), 32'(dut.wait_cnt), 32'(k));
    end
    tick();
    checkOutput("starve_wait_sat", 32'(dut.wait_cnt), 32'd4);
    bus.MemReady = 1'b1;
    #1;
    checkOutput("starve_d_done", 32'(bus.DValid), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h2004, 32'h0, 3'b010, 1'b1);
    #1;
    checkOutput("starve_i_won", 32'(bus.IValid), 32'd1);
    checkOutput("starve_wait_clr", 32'(dut.wait_cnt), 32'd0);
    checkOutput("starve_stall_d", 32'(bus.StallD), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 3'b010, 1'b1);
    #1;
    checkOutput("starve_d_again", 32'(bus.DValid), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    #1;
    checkOutput("starve_idle", 32'(bus.MemReq), 32'd0);

    // Store with three wait cycles; requester inputs change mid-transaction and must not leak through
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'hDEADBEEF, 3'b010, 1'b0);
    pushExpect(1'b1, 1'b1, 32'h3000, 32'hDEADBEEF, 3'b010);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k >= 2) begin
        bus.DAddr  = 32'h0000_FFFF;
        bus.DWData = 32'h1234_5678;
        bus.DCtrl  = 3'b101;
      end
      bus.MemReady = (k == 4);
      #1;
      checkOutput($sformatf("st_we_%0d", k),    32'(bus.MemWe), 32'd1);
      checkOutput($sformatf("st_addr_%0d", k),  bus.MemAddr, 32'h3000);
      checkOutput($sformatf("st_wdata_%0d", k), bus.MemWData, 32'hDEADBEEF);
      checkOutput($sformatf("st_ctrl_%0d", k),  32'(bus.MemCtrl), 32'd2);
      checkOutput($sformatf("st_dvalid_%0d", k), 32'(bus.DValid), 32'(k == 4));
    end
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
    #1;
    checkOutput("st_idle_we", 32'(bus.MemWe), 32'd0);
    checkOutput("st_idle_wdata", bus.MemWData, 32'd0);

    // Reset in the middle of a pending D load aborts it without a completion pulse
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h2010, 32'h0, 3'b010, 1'b0);
    tick();
    checkOutput("abort_busy", 32'(bus.MemReq), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("abort_memreq", 32'(bus.MemReq), 32'd0);
    checkOutput("abort_state", 32'(dut.state_q), 32'd0);
    bus.MemReady = 1'b1;
    #1;
    checkOutput("abort_no_dvalid", 32'(bus.DValid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("abort_stays_idle", 32'(bus.MemReq), 32'd0);

    tick();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
